// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer
// ----------------------------------------------------------------------------
// Debounces a vector of slide-switch inputs. Each bit is brought into the
// clk domain through its own two-flop synchronizer. A per-bit counter then
// measures how long the synchronized value has disagreed with the debounced
// value. The debounced bit only follows the input after DEBOUNCE_CYCLES
// consecutive disagreeing edges. Any agreeing edge restarts that count.
//
// Parameters
//   BITS            : width of the switch vector (1..32)
//   DEBOUNCE_CYCLES : consecutive disagreeing edges needed before a
//                     debounced bit changes (>= 1)
//
// Ports
//   clk        : system clock; all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   SW_RAW     : asynchronous, bouncy switch inputs
//   SW_DB      : debounced, clk-synchronous switch vector (flop outputs)
//   SW_CHANGED : one-cycle strobe in the cycle SW_DB takes a new value
//
// Build option
//   SWDB_CHANGE_STROBE_EN : when defined, SW_CHANGED is a registered strobe.
//                           When undefined, SW_CHANGED is tied to 0 and no
//                           strobe flop exists.
// ============================================================================
module switch_debouncer #(
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] SW_RAW,
    output logic [BITS-1:0] SW_DB,
    output logic            SW_CHANGED
);

    // The counter only has to hold values up to DEBOUNCE_CYCLES-1. The width
    // is still sized for DEBOUNCE_CYCLES so that a value of 1 gets a 1-bit counter.
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] COUNT_ZERO = '0;
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [BITS-1:0] sw_meta;
    logic [BITS-1:0] sw_sync;
    logic [CW-1:0]   count_q [BITS];
    logic [CW-1:0]   count_d [BITS];
    logic [BITS-1:0] db_next;

    // Two-flop synchronizer per bit. The first stage may go metastable.
    // Only the second stage (sw_sync) feeds the debounce logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW_RAW;
            sw_sync <= sw_meta;
        end
    end

    // Next-state logic for every bit.
    // - Agreement between sw_sync and SW_DB clears the count.
    // - A disagreement advances the count.
    // - On the final disagreeing edge the debounced bit flips and the count
    //   returns to zero instead of advancing.
    // Because the count never goes past COUNT_LAST, it cannot wrap.
    always_comb begin
        db_next = SW_DB;
        for (int i = 0; i < BITS; i++) begin
            count_d[i] = COUNT_ZERO;
            if (sw_sync[i] != SW_DB[i]) begin
                if (count_q[i] == COUNT_LAST) begin
                    db_next[i] = sw_sync[i];
                end else begin
                    count_d[i] = count_q[i] + COUNT_ONE;
                end
            end
        end
    end

    // Counter and debounced-output registers. Reset wins over everything,
    // so a partial count in progress is simply thrown away.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BITS; i++) begin
                count_q[i] <= COUNT_ZERO;
            end
            SW_DB <= '0;
        end else begin
            for (int i = 0; i < BITS; i++) begin
                count_q[i] <= count_d[i];
            end
            SW_DB <= db_next;
        end
    end

`ifdef SWDB_CHANGE_STROBE_EN
    // The strobe is registered from the same comparison that updates SW_DB.
    // It is therefore high exactly in the cycle SW_DB shows its new value.
    // Several bits flipping together still give one pulse. Flips on
    // back-to-back edges give back-to-back pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            SW_CHANGED <= 1'b0;
        end else begin
            SW_CHANGED <= (db_next != SW_DB);
        end
    end
`else
    // Strobe disabled: the port stays for interface compatibility.
    assign SW_CHANGED = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// tb_switch_debouncer
// ----------------------------------------------------------------------------
// Drives two debouncers (DEBOUNCE_CYCLES = 4 and = 1) from the same inputs.
// The reference model keeps a history of synchronized samples. A debounced bit
// flips when the last DEBOUNCE_CYCLES samples all disagree with it. Directed
// scenarios pin the model with literal expectations. A randomized phase
// follows them.
// ============================================================================
module tb_switch_debouncer;

    localparam int BITS = 16;
`ifdef SWDB_CHANGE_STROBE_EN
    localparam bit STROBE = 1'b1;
`else
    localparam bit STROBE = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [BITS-1:0] sw_raw;
    logic [BITS-1:0] db_a;
    logic [BITS-1:0] db_b;
    logic            changed_a;
    logic            changed_b;

    int tests_run;
    int tests_failed;

    switch_debouncer #(.BITS(BITS), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .SW_RAW     (sw_raw),
        .SW_DB      (db_a),
        .SW_CHANGED (changed_a)
    );

    switch_debouncer #(.BITS(BITS), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .SW_RAW     (sw_raw),
        .SW_DB      (db_b),
        .SW_CHANGED (changed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [BITS-1:0] m_s1;
    logic [BITS-1:0] m_s2;
    logic [BITS-1:0] m_db_a;
    logic [BITS-1:0] m_db_b;
    logic            m_ch_a;
    logic            m_ch_b;
    logic [BITS-1:0] hist_a[$];
    logic [BITS-1:0] hist_b[$];
    bit              model_valid;

    // Returns the new debounced value. A bit flips when each of the newest
    // 'depth' synchronized samples disagrees with its current debounced value.
    function automatic logic [BITS-1:0] settle(input logic [BITS-1:0] db,
                                               input logic [BITS-1:0] hist[$],
                                               input int depth);
        logic [BITS-1:0] res;
        bit all_diff;
        res = db;
        if (hist.size() >= depth) begin
            for (int b = 0; b < BITS; b++) begin
                all_diff = 1'b1;
                for (int k = hist.size() - depth; k < hist.size(); k++) begin
                    if (hist[k][b] == db[b]) all_diff = 1'b0;
                end
                if (all_diff) res[b] = ~db[b];
            end
        end
        return res;
    endfunction

    initial begin
        m_s1 = '0; m_s2 = '0; m_db_a = '0; m_db_b = '0;
        m_ch_a = 1'b0; m_ch_b = 1'b0; model_valid = 1'b0;
    end

    // The model advances on every rising edge. It uses the inputs as they
    // were driven before that edge.
    always @(posedge clk) begin
        logic [BITS-1:0] nxt;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_db_a = '0; m_db_b = '0;
            m_ch_a = 1'b0; m_ch_b = 1'b0;
            hist_a = {};
            hist_b = {};
            for (int k = 0; k < 4; k++) hist_a.push_back('0);
            hist_b.push_back('0);
            model_valid = 1'b1;
        end else begin
            hist_a.push_back(m_s2);
            if (hist_a.size() > 4) void'(hist_a.pop_front());
            hist_b.push_back(m_s2);
            if (hist_b.size() > 1) void'(hist_b.pop_front());
            nxt    = settle(m_db_a, hist_a, 4);
            m_ch_a = (nxt != m_db_a);
            m_db_a = nxt;
            nxt    = settle(m_db_b, hist_b, 1);
            m_ch_b = (nxt != m_db_b);
            m_db_b = nxt;
            m_s2   = m_s1;
            m_s1   = sw_raw;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [BITS-1:0] actual,
                               input logic [BITS-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // The compare process checks both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_db_a", db_a, m_db_a);
            checkOutput("model_db_b", db_b, m_db_b);
            checkOutput("model_changed_a", {15'd0, changed_a}, {15'd0, STROBE & m_ch_a});
            checkOutput("model_changed_b", {15'd0, changed_b}, {15'd0, STROBE & m_ch_b});
        end
    end

    // Drives inputs just after a rising edge, then lets 'cycles' rising edges pass.
    task automatic applyStimulus(input logic rst, input logic [BITS-1:0] raw, input int cycles);
        reset  = rst;
        sw_raw = raw;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [BITS-1:0] rnd_raw;
    logic            rnd_rst;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held with all switches on, then released.
        applyStimulus(1'b1, 16'hFFFF, 3);
        checkOutput("rst_db_a", db_a, 16'h0000);
        checkOutput("rst_db_b", db_b, 16'h0000);
        checkOutput("rst_changed_a", {15'd0, changed_a}, 16'h0000);
        applyStimulus(1'b0, 16'hFFFF, 2);
        checkOutput("rel2_db_b", db_b, 16'h0000);
        applyStimulus(1'b0, 16'hFFFF, 1);
        checkOutput("rel3_db_b", db_b, 16'hFFFF);
        applyStimulus(1'b0, 16'hFFFF, 2);
        checkOutput("rel5_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'hFFFF, 1);
        checkOutput("rel6_db_a", db_a, 16'hFFFF);
        checkOutput("rel6_changed_a", {15'd0, changed_a}, {15'd0, STROBE});
        applyStimulus(1'b0, 16'hFFFF, 1);
        checkOutput("rel7_changed_a", {15'd0, changed_a}, 16'h0000);

        // A 3-cycle glitch on bit 3 is shorter than the debounce window.
        applyStimulus(1'b0, 16'h0000, 12);
        checkOutput("settle0_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'h0008, 3);
        applyStimulus(1'b0, 16'h0000, 8);
        checkOutput("glitch_db_a", db_a, 16'h0000);

        // Bit 15 bounces 1,0,1,1,0 and then settles high.
        applyStimulus(1'b0, 16'h8000, 1);
        applyStimulus(1'b0, 16'h0000, 1);
        applyStimulus(1'b0, 16'h8000, 2);
        applyStimulus(1'b0, 16'h0000, 1);
        applyStimulus(1'b0, 16'h8000, 5);
        checkOutput("bounce5_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'h8000, 1);
        checkOutput("bounce6_db_a", db_a, 16'h8000);
        applyStimulus(1'b0, 16'h0000, 12);

        // Independent bits: bit 0 raised after edge 0, bit 7 raised after edge 2.
        applyStimulus(1'b0, 16'h0000, 1);
        applyStimulus(1'b0, 16'h0001, 2);
        applyStimulus(1'b0, 16'h0081, 3);
        checkOutput("indep5_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'h0081, 1);
        checkOutput("indep6_db_a", db_a, 16'h0001);
        checkOutput("indep6_changed_a", {15'd0, changed_a}, {15'd0, STROBE});
        applyStimulus(1'b0, 16'h0081, 1);
        checkOutput("indep7_db_a", db_a, 16'h0001);
        checkOutput("indep7_changed_a", {15'd0, changed_a}, 16'h0000);
        applyStimulus(1'b0, 16'h0081, 1);
        checkOutput("indep8_db_a", db_a, 16'h0081);
        checkOutput("indep8_changed_a", {15'd0, changed_a}, {15'd0, STROBE});
        applyStimulus(1'b0, 16'h0000, 12);

        // Reset pulse at edge 4 discards the partial count for bit 5.
        applyStimulus(1'b0, 16'h0000, 1);
        applyStimulus(1'b0, 16'h0020, 3);
        applyStimulus(1'b1, 16'h0020, 1);
        checkOutput("midrst_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'h0020, 5);
        checkOutput("midrst5_db_a", db_a, 16'h0000);
        applyStimulus(1'b0, 16'h0020, 1);
        checkOutput("midrst6_db_a", db_a, 16'h0020);
        applyStimulus(1'b0, 16'h0000, 12);

        // Minimum debounce length: the D=1 instance follows after 3 edges.
        applyStimulus(1'b0, 16'hA5A5, 2);
        checkOutput("min2_db_b", db_b, 16'h0000);
        applyStimulus(1'b0, 16'hA5A5, 1);
        checkOutput("min3_db_b", db_b, 16'hA5A5);
        checkOutput("min3_changed_b", {15'd0, changed_b}, {15'd0, STROBE});
        applyStimulus(1'b0, 16'hA5A5, 12);

        // Randomized phase: sparse multi-bit changes, single-bit bounces and
        // occasional resets.
        rnd_raw = 16'hA5A5;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) rnd_raw = rnd_raw ^ 16'($urandom);
            if ($urandom_range(0, 3) == 0) rnd_raw = rnd_raw ^ (16'(1) << $urandom_range(0, 15));
            rnd_rst = ($urandom_range(0, 99) == 0);
            applyStimulus(rnd_rst, rnd_raw, 1);
        end
        applyStimulus(1'b0, rnd_raw, 10);
        checkOutput("final_db_a", db_a, rnd_raw);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter BITS, default 16: width of the switch vector; legal range 1..32.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: required stable-input cycles before a debounced bit changes (5 ms at 100 MHz); legal range ≥ 1.
REQ-003 The block SHALL have input clk, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have input SW_RAW, BITS bits: asynchronous, bouncy slide-switch inputs.
REQ-006 The block SHALL have output SW_DB, BITS bits: debounced, clk-synchronous switch vector that feeds the leading-ones encoder SW input.
REQ-007 The block SHALL have output SW_CHANGED, 1 bit: one-cycle strobe when SW_DB changes value.

Function
REQ-008 Each SW_RAW bit SHALL pass through a 2-flop synchronizer; sw_sync[i] is the second flop output.
REQ-009 Each bit SHALL own an independent counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-010 When sw_sync[i] == SW_DB[i], counter[i] SHALL clear to 0 on the next edge.
REQ-011 When sw_sync[i] != SW_DB[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-012 When sw_sync[i] != SW_DB[i] and counter[i] == DEBOUNCE_CYCLES-1, SW_DB[i] SHALL take sw_sync[i] and counter[i] SHALL clear to 0 on the same edge.
REQ-013 A single mismatch cycle followed by a return to agreement (a glitch shorter than DEBOUNCE_CYCLES) SHALL leave SW_DB[i] unchanged and restart the count from 0.
REQ-014 Latency: a raw change held stable SHALL appear on SW_DB exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
REQ-015 With DEBOUNCE_CYCLES == 1, a bit SHALL update on the first mismatch edge; the counter SHALL never exceed 0.
REQ-016 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each follow REQ-010..012 with no interaction.
REQ-017 The counter SHALL never wrap; it is bounded by REQ-011/012.
REQ-018 SW_DB SHALL be driven directly from flops, with no combinational path from SW_RAW.

Reset
REQ-019 While reset is high at a rising edge, the synchronizer flops, all counters, SW_DB, and SW_CHANGED SHALL load 0.
REQ-020 Reset asserted mid-count SHALL discard the partial count; after release, a switch already on SHALL reach SW_DB after DEBOUNCE_CYCLES+2 edges.
REQ-021 Reset SHALL take priority over every other update in the same cycle.

Configuration
REQ-022 Macro SWDB_CHANGE_STROBE_EN SHALL control the SW_CHANGED logic.
REQ-023 With SWDB_CHANGE_STROBE_EN defined, SW_CHANGED SHALL be a registered output, high for exactly the one cycle in which SW_DB first differs from its value on the previous cycle.
REQ-024 With SWDB_CHANGE_STROBE_EN defined, multiple bits updating on the same edge SHALL produce a single one-cycle pulse, and updates on consecutive edges SHALL produce consecutive pulses.
REQ-025 With SWDB_CHANGE_STROBE_EN undefined, the SW_CHANGED port SHALL remain present but be tied to 0, and no strobe flop SHALL be inferred.

Verification (BITS=16, DEBOUNCE_CYCLES=4 unless stated)
REQ-026 Reset scenario: hold reset 3 cycles with SW_RAW=16'hFFFF, then release -> SW_DB=0 during reset, SW_DB=16'hFFFF exactly 6 edges after release, and SW_CHANGED pulses once (strobe build).
REQ-027 Glitch-rejection scenario: with SW_DB=0, toggle SW_RAW[3] high for 3 cycles and back low -> SW_DB stays 16'h0000 and SW_CHANGED stays 0.
REQ-028 Bounce-then-settle scenario: drive SW_RAW[15] with pattern 1,0,1,1,0 then hold at 1 -> SW_DB[15] rises exactly 6 edges after the final 0->1 sampled edge, and never earlier.
REQ-029 Independent-bits scenario: raise SW_RAW[0] at edge 0 and SW_RAW[7] at edge 2 -> SW_DB becomes 16'h0001 at edge 6 and 16'h0081 at edge 8, with two separate SW_CHANGED pulses.
REQ-030 Reset mid-count scenario: raise SW_RAW[5], assert reset 1 cycle at edge 4, then hold SW_RAW[5]=1 -> SW_DB[5] is 0 until exactly 6 edges after reset release.
REQ-031 Minimum-parameter scenario: with DEBOUNCE_CYCLES=1 and SWDB_CHANGE_STROBE_EN undefined, step SW_RAW to 16'hA5A5 -> SW_DB=16'hA5A5 after 3 edges and SW_CHANGED stays 0 throughout.
